// File: rtl/sram_pkg.sv
// Shared definitions for the external async SRAM arbiter: bus widths, arbiter state
// encodings and default access timing.
package sram_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam int DEF_ACCESS_CYCLES  = 2;
  localparam int DEF_MAX_VID_STREAK = 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_READ  = 2'd1;
  localparam arb_state_t ST_WRITE = 2'd2;
  localparam arb_state_t ST_TURN  = 2'd3;

endpackage

// File: rtl/sram_access_seq.sv
// Per-access cycle counter and registered SRAM strobe generation. A start pulse in the
// cycle before an access makes the next ACCESS_CYCLES cycles drive the strobes.
module sram_access_seq
  import sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       start,
  input  logic       is_write,
  input  logic [1:0] be,
  output logic       last,
  output logic       ram_ce,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       ram_lb,
  output logic       ram_hb,
  output logic       ram_dout_en
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

  logic          active_q, active_d;
  logic          write_q, write_d;
  logic [1:0]    lanes_q, lanes_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, ce_d, oe_q, oe_d, we_q, we_d;
  logic          lb_q, lb_d, hb_q, hb_d, den_q, den_d;

  assign last = active_q && (cnt_q == LAST_CNT);

  // Strobes are computed from the next-cycle access state so they leave a flop.
  always_comb begin
    active_d = active_q;
    write_d  = write_q;
    lanes_d  = lanes_q;
    cnt_d    = cnt_q;
    if (start) begin
      active_d = 1'b1;
      write_d  = is_write;
      lanes_d  = is_write ? be : 2'b11;
      cnt_d    = '0;
    end else if (last) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (active_q) begin
      cnt_d = cnt_q + CW'(1);
    end

    ce_d  = ~active_d;
    oe_d  = ~(active_d & ~write_d);
    // Cycle 0 of a write is address setup only.
    we_d  = ~(active_d & write_d & (cnt_d != '0));
    lb_d  = ~(active_d & lanes_d[0]);
    hb_d  = ~(active_d & lanes_d[1]);
    den_d = active_d & write_d;
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      write_q  <= 1'b0;
      lanes_q  <= 2'b00;
      cnt_q    <= '0;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      lb_q     <= 1'b1;
      hb_q     <= 1'b1;
      den_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      write_q  <= write_d;
      lanes_q  <= lanes_d;
      cnt_q    <= cnt_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      lb_q     <= lb_d;
      hb_q     <= hb_d;
      den_q    <= den_d;
    end
  end

  assign ram_ce      = ce_q;
  assign ram_oe      = oe_q;
  assign ram_we      = we_q;
  assign ram_lb      = lb_q;
  assign ram_hb      = hb_q;
  assign ram_dout_en = den_q;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between the video line-fetch port and the host/blitter port.
// Video has priority; a streak counter forces a host grant after MAX_VID_STREAK video grants.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ACCESS_CYCLES  = DEF_ACCESS_CYCLES,
  parameter int MAX_VID_STREAK = DEF_MAX_VID_STREAK
) (
  input  logic               clk100,
  input  logic               rst_n,
  input  logic               vid_req,
  input  logic [SRAM_AW-1:0] vid_addr,
  output logic               vid_ack,
  output logic [SRAM_DW-1:0] vid_rdata,
  output logic               vid_rvalid,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [SRAM_AW-1:0] host_addr,
  input  logic [SRAM_DW-1:0] host_wdata,
  input  logic [1:0]         host_be,
  output logic               host_ack,
  output logic [SRAM_DW-1:0] host_rdata,
  output logic               host_rvalid,
  output logic [SRAM_AW-1:0] ram_addr,
  input  logic [SRAM_DW-1:0] ram_din,
  output logic [SRAM_DW-1:0] ram_dout,
  output logic               ram_dout_en,
  output logic               ram_ce,
  output logic               ram_oe,
  output logic               ram_we,
  output logic               ram_lb,
  output logic               ram_hb
);

  localparam int SW = $clog2(MAX_VID_STREAK + 1);
  localparam logic [SW-1:0] MAX_STREAK = SW'(MAX_VID_STREAK);

  arb_state_t         state_q, state_d;
  logic [SW-1:0]      streak_q, streak_d;
  logic               owner_vid_q, owner_vid_d;
  logic [SRAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [SRAM_DW-1:0] ram_dout_q, ram_dout_d;
  logic               vid_ack_q, vid_ack_d, host_ack_q, host_ack_d;
  logic               vid_rvalid_q, vid_rvalid_d, host_rvalid_q, host_rvalid_d;
  logic [SRAM_DW-1:0] vid_rdata_q, vid_rdata_d, host_rdata_q, host_rdata_d;

  logic seq_start, seq_write, seq_last;
  logic decide, host_forced;

  sram_access_seq #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_seq (
    .clk100     (clk100),
    .rst_n      (rst_n),
    .start      (seq_start),
    .is_write   (seq_write),
    .be         (host_be),
    .last       (seq_last),
    .ram_ce     (ram_ce),
    .ram_oe     (ram_oe),
    .ram_we     (ram_we),
    .ram_lb     (ram_lb),
    .ram_hb     (ram_hb),
    .ram_dout_en(ram_dout_en)
  );

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    owner_vid_d   = owner_vid_q;
    ram_addr_d    = ram_addr_q;
    ram_dout_d    = ram_dout_q;
    vid_ack_d     = 1'b0;
    host_ack_d    = 1'b0;
    vid_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    vid_rdata_d   = vid_rdata_q;
    host_rdata_d  = host_rdata_q;
    seq_start     = 1'b0;
    seq_write     = 1'b0;

    decide      = (state_q == ST_IDLE) ||
                  (((state_q == ST_READ) || (state_q == ST_WRITE)) && seq_last);
    host_forced = host_req && (streak_q == MAX_STREAK);

    if (!host_req) streak_d = '0;

    if ((state_q == ST_READ) && seq_last) begin
      if (owner_vid_q) begin
        vid_rdata_d  = ram_din;
        vid_rvalid_d = 1'b1;
      end else begin
        host_rdata_d  = ram_din;
        host_rvalid_d = 1'b1;
      end
    end

    // A host write that won after a read waits out the TURN cycle before its access starts.
    if (state_q == ST_TURN) begin
      state_d     = ST_WRITE;
      seq_start   = 1'b1;
      seq_write   = 1'b1;
      host_ack_d  = 1'b1;
      owner_vid_d = 1'b0;
      ram_addr_d  = host_addr;
      ram_dout_d  = host_wdata;
    end else if (decide) begin
      if (vid_req && !host_forced) begin
        state_d     = ST_READ;
        seq_start   = 1'b1;
        vid_ack_d   = 1'b1;
        owner_vid_d = 1'b1;
        ram_addr_d  = vid_addr;
        streak_d    = host_req ? streak_q + SW'(1) : '0;
      end else if (host_req) begin
        streak_d = '0;
        if (host_we && (state_q == ST_READ)) begin
          state_d = ST_TURN;
        end else begin
          state_d     = host_we ? ST_WRITE : ST_READ;
          seq_start   = 1'b1;
          seq_write   = host_we;
          host_ack_d  = 1'b1;
          owner_vid_d = 1'b0;
          ram_addr_d  = host_addr;
          if (host_we) ram_dout_d = host_wdata;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      streak_q      <= '0;
      owner_vid_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_dout_q    <= '0;
      vid_ack_q     <= 1'b0;
      host_ack_q    <= 1'b0;
      vid_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      vid_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      owner_vid_q   <= owner_vid_d;
      ram_addr_q    <= ram_addr_d;
      ram_dout_q    <= ram_dout_d;
      vid_ack_q     <= vid_ack_d;
      host_ack_q    <= host_ack_d;
      vid_rvalid_q  <= vid_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      vid_rdata_q   <= vid_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_dout    = ram_dout_q;
  assign vid_ack     = vid_ack_q;
  assign host_ack    = host_ack_q;
  assign vid_rvalid  = vid_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign vid_rdata   = vid_rdata_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with a behavioural async SRAM model.
module tb_sram_arbiter;

  logic        clk100 = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_req = 1'b0;
  logic [17:0] vid_addr = '0;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        vid_rvalid;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [17:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [1:0]  host_be = 2'b00;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic [17:0] ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        ram_dout_en;
  logic        ram_ce, ram_oe, ram_we, ram_lb, ram_hb;

  logic [15:0] mem [0:262143];
  int tests = 0;
  int fails = 0;
  int conflicts = 0;

  always #5 clk100 = ~clk100;

  sram_arbiter dut (
    .clk100     (clk100),
    .rst_n      (rst_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_be    (host_be),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_dout_en(ram_dout_en),
    .ram_ce     (ram_ce),
    .ram_oe     (ram_oe),
    .ram_we     (ram_we),
    .ram_lb     (ram_lb),
    .ram_hb     (ram_hb)
  );

  // SRAM model: combinational read while selected, byte-lane write while we is low.
  assign ram_din = (!ram_ce && !ram_oe) ? mem[ram_addr] : 16'h0000;

  always @(posedge clk100) begin
    if (!ram_ce && !ram_we) begin
      if (!ram_lb) mem[ram_addr][7:0]  <= ram_dout[7:0];
      if (!ram_hb) mem[ram_addr][15:8] <= ram_dout[15:8];
    end
  end

  always @(negedge clk100) begin
    if (!ram_oe && ram_dout_en) conflicts = conflicts + 1;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk100);
    tests++;
    if ({ram_ce, ram_oe, ram_we, ram_lb, ram_hb} !== 5'b11111) begin
      fails++;
      $display("[TB] FAIL reset_strobes: got %b expected 11111", {ram_ce, ram_oe, ram_we, ram_lb, ram_hb});
    end
    tests++;
    if ({ram_addr, ram_dout, ram_dout_en} !== 35'd0) begin
      fails++;
      $display("[TB] FAIL reset_bus: got addr=%h dout=%h den=%b expected 0", ram_addr, ram_dout, ram_dout_en);
    end
    tests++;
    if ({vid_ack, host_ack, vid_rvalid, host_rvalid} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_handshake: got %b expected 0000", {vid_ack, host_ack, vid_rvalid, host_rvalid});
    end
    tests++;
    if ({vid_rdata, host_rdata} !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_rdata: got %h expected 0", {vid_rdata, host_rdata});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk100);
  endtask

  task automatic test_video_read;
    int t_ack = -1, t_rv = -1, n_ack = 0, oe_low = 0, we_low = 0;
    logic [15:0] rd = '0;
    mem[18'h00123] = 16'hBEEF;
    vid_addr = 18'h00123;
    vid_req  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk100);
      if (vid_ack) begin
        n_ack++;
        if (t_ack < 0) t_ack = c;
        vid_req = 1'b0;
      end
      if (vid_rvalid && t_rv < 0) begin
        t_rv = c;
        rd = vid_rdata;
      end
      if (!ram_oe) oe_low++;
      if (!ram_we) we_low++;
    end
    tests++;
    if (n_ack !== 1) begin
      fails++;
      $display("[TB] FAIL vid_read_acks: got %0d expected 1", n_ack);
    end
    tests++;
    if (t_ack < 0 || t_rv - t_ack !== 2) begin
      fails++;
      $display("[TB] FAIL vid_read_latency: got ack=%0d rvalid=%0d expected distance 2", t_ack, t_rv);
    end
    tests++;
    if (rd !== 16'hBEEF) begin
      fails++;
      $display("[TB] FAIL vid_read_data: got %h expected beef", rd);
    end
    tests++;
    if (oe_low !== 2) begin
      fails++;
      $display("[TB] FAIL vid_read_oe_cycles: got %0d expected 2", oe_low);
    end
    tests++;
    if (we_low !== 0) begin
      fails++;
      $display("[TB] FAIL vid_read_we_cycles: got %0d expected 0", we_low);
    end
  endtask

  task automatic test_host_write;
    int t_ack = -1, t_we = -1, lb_low = 0, hb_low = 0, we_low = 0, den = 0, bad_dout = 0;
    mem[18'h3FFFF] = 16'hAAAA;
    host_addr  = 18'h3FFFF;
    host_wdata = 16'h1234;
    host_be    = 2'b01;
    host_we    = 1'b1;
    host_req   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk100);
      if (host_ack) begin
        if (t_ack < 0) t_ack = c;
        host_req = 1'b0;
      end
      if (!ram_lb) lb_low++;
      if (!ram_hb) hb_low++;
      if (!ram_we) begin
        we_low++;
        if (t_we < 0) t_we = c;
      end
      if (ram_dout_en) begin
        den++;
        if (ram_dout !== 16'h1234) bad_dout++;
      end
    end
    tests++;
    if ({lb_low, hb_low} !== {32'd2, 32'd0}) begin
      fails++;
      $display("[TB] FAIL host_write_lanes: got lb=%0d hb=%0d expected lb=2 hb=0", lb_low, hb_low);
    end
    tests++;
    if (we_low !== 1 || t_ack < 0 || t_we - t_ack !== 1) begin
      fails++;
      $display("[TB] FAIL host_write_we_window: got count=%0d ack=%0d we=%0d expected one cycle after ack", we_low, t_ack, t_we);
    end
    tests++;
    if (den !== 2 || bad_dout !== 0) begin
      fails++;
      $display("[TB] FAIL host_write_dout: got den=%0d bad=%0d expected den=2 bad=0", den, bad_dout);
    end
    tests++;
    if (mem[18'h3FFFF] !== 16'hAA34) begin
      fails++;
      $display("[TB] FAIL host_write_mem: got %h expected aa34", mem[18'h3FFFF]);
    end
  endtask

  task automatic test_be_zero;
    int lane_low = 0, we_low = 0, n_ack = 0;
    mem[18'h00010] = 16'h1111;
    host_addr  = 18'h00010;
    host_wdata = 16'hFFFF;
    host_be    = 2'b00;
    host_we    = 1'b1;
    host_req   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk100);
      if (host_ack) begin
        n_ack++;
        host_req = 1'b0;
      end
      if (!ram_lb || !ram_hb) lane_low++;
      if (!ram_we) we_low++;
    end
    tests++;
    if ({n_ack, we_low, lane_low} !== {32'd1, 32'd1, 32'd0}) begin
      fails++;
      $display("[TB] FAIL be_zero_access: got ack=%0d we=%0d lanes=%0d expected 1 1 0", n_ack, we_low, lane_low);
    end
    tests++;
    if (mem[18'h00010] !== 16'h1111) begin
      fails++;
      $display("[TB] FAIL be_zero_mem: got %h expected 1111", mem[18'h00010]);
    end
  endtask

  task automatic test_streak;
    int rounds [3] = '{-1, -1, -1};
    int nv = 0, nh = 0;
    vid_addr  = 18'h00100;
    host_addr = 18'h00200;
    host_we   = 1'b0;
    vid_req   = 1'b1;
    host_req  = 1'b1;
    for (int c = 0; c < 90 && nh < 3; c++) begin
      @(negedge clk100);
      if (vid_ack) nv++;
      if (host_ack) begin
        rounds[nh] = nv;
        nh++;
        nv = 0;
      end
    end
    vid_req  = 1'b0;
    host_req = 1'b0;
    repeat (4) @(negedge clk100);
    tests++;
    if (nh !== 3) begin
      fails++;
      $display("[TB] FAIL streak_host_grants: got %0d expected 3", nh);
    end
    for (int r = 0; r < 3; r++) begin
      tests++;
      if (rounds[r] !== 8) begin
        fails++;
        $display("[TB] FAIL streak_round%0d: got %0d video grants expected 8", r, rounds[r]);
      end
    end
  endtask

  task automatic test_read_to_write;
    logic ce_log [16];
    logic oe_log [16];
    logic den_log [16];
    logic [2:0] turn_obs = 3'b000;
    int last_oe = -1, first_den = -1, t_hack = -1;
    conflicts = 0;
    vid_addr   = 18'h00300;
    host_addr  = 18'h00301;
    host_wdata = 16'h0F0F;
    host_be    = 2'b11;
    host_we    = 1'b1;
    vid_req    = 1'b1;
    host_req   = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk100);
      if (vid_ack) vid_req = 1'b0;
      if (host_ack) begin
        if (t_hack < 0) t_hack = c;
        host_req = 1'b0;
      end
      ce_log[c]  = ram_ce;
      oe_log[c]  = ram_oe;
      den_log[c] = ram_dout_en;
      if (!ram_oe) last_oe = c;
      if (ram_dout_en && first_den < 0) first_den = c;
    end
    if (last_oe >= 0 && last_oe < 15) turn_obs = {ce_log[last_oe+1], oe_log[last_oe+1], den_log[last_oe+1]};
    tests++;
    if (last_oe < 0 || first_den - last_oe !== 2) begin
      fails++;
      $display("[TB] FAIL turn_gap: got last_oe=%0d first_den=%0d expected one cycle between", last_oe, first_den);
    end
    tests++;
    if (turn_obs !== 3'b110) begin
      fails++;
      $display("[TB] FAIL turn_strobes: got ce/oe/den=%b expected 110", turn_obs);
    end
    tests++;
    if (t_hack < 0 || t_hack !== first_den) begin
      fails++;
      $display("[TB] FAIL turn_host_ack: got ack=%0d expected %0d", t_hack, first_den);
    end
    tests++;
    if (conflicts !== 0) begin
      fails++;
      $display("[TB] FAIL bus_conflict: got %0d expected 0", conflicts);
    end
  endtask

  task automatic test_write_to_read;
    int t_hack = -1, t_rv = -1, idle = 0;
    logic ce_log [16];
    logic [15:0] rd = '0;
    mem[18'h00456] = 16'h0000;
    host_addr  = 18'h00456;
    host_wdata = 16'hCAFE;
    host_be    = 2'b11;
    host_we    = 1'b1;
    host_req   = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk100);
      ce_log[c] = ram_ce;
      if (host_ack) begin
        if (t_hack < 0) t_hack = c;
        host_req = 1'b0;
        vid_addr = 18'h00456;
        vid_req  = 1'b1;
      end
      if (vid_ack) vid_req = 1'b0;
      if (vid_rvalid && t_rv < 0) begin
        t_rv = c;
        rd = vid_rdata;
      end
    end
    if (t_hack >= 0 && t_rv > t_hack) begin
      for (int c = t_hack; c < t_rv; c++) if (ce_log[c]) idle++;
    end
    tests++;
    if (t_hack < 0 || t_rv - t_hack !== 4 || idle !== 0) begin
      fails++;
      $display("[TB] FAIL write_read_no_idle: got ack=%0d rvalid=%0d idle=%0d expected distance 4 idle 0", t_hack, t_rv, idle);
    end
    tests++;
    if (rd !== 16'hCAFE) begin
      fails++;
      $display("[TB] FAIL write_read_data: got %h expected cafe", rd);
    end
  endtask

  task automatic test_reset_mid_write;
    int acked = 0, stray = 0, n_ack = 0, t_ack = -1, t_rv = -1;
    logic [15:0] rd = '0;
    mem[18'h00789] = 16'h0000;
    host_addr  = 18'h00789;
    host_wdata = 16'h5555;
    host_be    = 2'b11;
    host_we    = 1'b1;
    host_req   = 1'b1;
    for (int c = 0; c < 6 && acked == 0; c++) begin
      @(negedge clk100);
      if (host_ack) acked = 1;
    end
    @(posedge clk100);
    #1;
    rst_n    = 1'b0;
    host_req = 1'b0;
    #1;
    tests++;
    if ({acked[0], ram_ce, ram_we, ram_dout_en} !== 4'b1110) begin
      fails++;
      $display("[TB] FAIL reset_mid_write_strobes: got acked/ce/we/den=%b expected 1110", {acked[0], ram_ce, ram_we, ram_dout_en});
    end
    repeat (2) @(negedge clk100);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk100);
      if (host_ack || host_rvalid) stray++;
    end
    tests++;
    if (stray !== 0) begin
      fails++;
      $display("[TB] FAIL reset_mid_write_stray: got %0d handshakes expected 0", stray);
    end
    host_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk100);
      if (host_ack) begin
        n_ack++;
        host_req = 1'b0;
      end
    end
    tests++;
    if (n_ack !== 1 || mem[18'h00789] !== 16'h5555) begin
      fails++;
      $display("[TB] FAIL reset_recover_write: got acks=%0d mem=%h expected 1 5555", n_ack, mem[18'h00789]);
    end
    host_we  = 1'b0;
    host_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk100);
      if (host_ack) begin
        if (t_ack < 0) t_ack = c;
        host_req = 1'b0;
      end
      if (host_rvalid && t_rv < 0) begin
        t_rv = c;
        rd = host_rdata;
      end
    end
    tests++;
    if (t_ack < 0 || t_rv - t_ack !== 2 || rd !== 16'h5555) begin
      fails++;
      $display("[TB] FAIL host_read_back: got ack=%0d rvalid=%0d data=%h expected distance 2 data 5555", t_ack, t_rv, rd);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_video_read();
    test_host_write();
    test_be_zero();
    test_streak();
    test_read_to_write();
    test_write_to_read();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
